// File: rtl/sonic_zone_filter.sv
// sonic_zone_filter: samples a ranging distance, clamps it, averages the last 4 samples
// and classifies the average into CLEAR/WARN/STOP zones with hysteresis.
module sonic_zone_filter #(
    parameter int SAMPLE_CYCLES = 10_000_000,
    parameter int MAX_CM = 400,
    parameter int STOP_CM = 20,
    parameter int WARN_CM = 50,
    parameter int HYST_CM = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] distance,
    output logic [19:0] avg_cm,
    output logic        sample_valid,
    output logic [1:0]  zone,
    output logic        stop
);
    localparam int TW = $clog2(SAMPLE_CYCLES);
    localparam logic [1:0] CLEAR = 2'b00;
    localparam logic [1:0] WARN = 2'b01;
    localparam logic [1:0] STOP = 2'b10;
    localparam logic [19:0] MAX = 20'(MAX_CM);
    localparam logic [19:0] STOP_IN = 20'(STOP_CM);
    localparam logic [19:0] WARN_IN = 20'(WARN_CM);
    localparam logic [19:0] STOP_OUT = 20'(STOP_CM + HYST_CM);
    localparam logic [19:0] WARN_OUT = 20'(WARN_CM + HYST_CM);

    logic [19:0] d_q;
    logic [TW-1:0] timer;
    logic tick;
    logic tick_q;
    logic [19:0] clamped;
    logic [19:0] w [4];
    logic [21:0] sum;
    logic [1:0] next_zone;

    assign tick = timer == TW'(SAMPLE_CYCLES - 1);
    // a zero reading means no echo, so it is treated as "far away"
    assign clamped = (d_q == '0 || d_q > MAX) ? MAX : d_q;

    always_comb begin
        next_zone = zone == STOP ? (avg_cm >= WARN_OUT ? CLEAR : avg_cm >= STOP_OUT ? WARN : STOP)
                  : avg_cm < STOP_IN ? STOP
                  : zone == WARN ? (avg_cm >= WARN_OUT ? CLEAR : WARN)
                  : (avg_cm < WARN_IN ? WARN : CLEAR);
    end

    always_ff @(posedge clk) begin
        d_q <= distance;
        if (rst) begin
            timer <= '0;
            tick_q <= 1'b0;
            w <= '{default: MAX};
            sum <= 22'(4 * MAX_CM);
            avg_cm <= MAX;
            sample_valid <= 1'b0;
            zone <= CLEAR;
            stop <= 1'b0;
        end else begin
            timer <= tick ? '0 : timer + TW'(1);
            tick_q <= tick;
            sample_valid <= tick_q;
            if (tick) begin
                w[0] <= clamped;
                w[1] <= w[0];
                w[2] <= w[1];
                w[3] <= w[2];
                sum <= sum + 22'(clamped) - 22'(w[3]);
            end
            if (tick_q)
                avg_cm <= sum[21:2];
            if (sample_valid) begin
                zone <= next_zone;
                stop <= next_zone == STOP;
            end
        end
    end
endmodule

// File: tb/tb_sonic_zone_filter.sv
// tb_sonic_zone_filter: directed vector bench for sonic_zone_filter with SAMPLE_CYCLES = 8.
module tb_sonic_zone_filter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [19:0] distance = 20'd400;
    logic [19:0] avg_cm;
    logic sample_valid;
    logic [1:0] zone;
    logic stop;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [19:0] d;
        logic [19:0] avg;
        logic [1:0]  zone;
    } vec_t;

    vec_t vt [24];

    sonic_zone_filter #(.SAMPLE_CYCLES(8)) dut (
        .clk(clk),
        .rst(rst),
        .distance(distance),
        .avg_cm(avg_cm),
        .sample_valid(sample_valid),
        .zone(zone),
        .stop(stop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_pulse(output int cyc);
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (sample_valid === 1'b1) break;
            if (cyc > 40) begin
                n_bad++;
                $display("FAIL pulse_timeout: got no pulse expected one within 40 cycles");
                break;
            end
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_avg"}, 32'(avg_cm), 32'd400);
        chk({tag, "_zone"}, 32'(zone), 32'd0);
        chk({tag, "_stop"}, 32'(stop), 32'd0);
        chk({tag, "_sv"}, 32'(sample_valid), 32'd0);
    endtask

    task automatic sample(input string tag, input logic [19:0] exp_avg, input logic [1:0] exp_zone);
        int cyc;
        wait_pulse(cyc);
        chk({tag, "_avg"}, 32'(avg_cm), 32'(exp_avg));
        @(negedge clk);
        chk({tag, "_zone"}, 32'(zone), 32'(exp_zone));
        chk({tag, "_stop"}, 32'(stop), 32'(exp_zone == 2'b10));
        chk({tag, "_sv_low"}, 32'(sample_valid), 32'd0);
    endtask

    initial begin
        int cyc;
        vt = '{
            '{20'd10, 20'd302, 2'b00}, '{20'd10, 20'd205, 2'b00},
            '{20'd10, 20'd107, 2'b00}, '{20'd10, 20'd10, 2'b10},
            '{20'd24, 20'd13, 2'b10}, '{20'd24, 20'd17, 2'b10},
            '{20'd24, 20'd20, 2'b10}, '{20'd24, 20'd24, 2'b10},
            '{20'd25, 20'd24, 2'b10}, '{20'd25, 20'd24, 2'b10},
            '{20'd25, 20'd24, 2'b10}, '{20'd25, 20'd25, 2'b01},
            '{20'd30, 20'd26, 2'b01}, '{20'd30, 20'd27, 2'b01},
            '{20'd30, 20'd28, 2'b01}, '{20'd30, 20'd30, 2'b01},
            '{20'd0, 20'd122, 2'b00}, '{20'd1000, 20'd215, 2'b00},
            '{20'd0, 20'd307, 2'b00}, '{20'd1000, 20'd400, 2'b00},
            '{20'd60, 20'd315, 2'b00}, '{20'd45, 20'd226, 2'b00},
            '{20'd45, 20'd137, 2'b00}, '{20'd45, 20'd48, 2'b01}
        };

        // reset held for 3 cycles, then first pulse and periodicity
        step;
        @(negedge clk);
        chk_reset_state("rst1");
        step;
        @(negedge clk);
        chk_reset_state("rst2");
        step;
        rst = 1'b0;
        wait_pulse(cyc);
        chk("first_pulse_cycle", 32'(cyc), 32'd10);
        chk("first_avg", 32'(avg_cm), 32'd400);
        for (int i = 0; i < 3; i++) begin
            wait_pulse(cyc);
            chk("pulse_period", 32'(cyc), 32'd8);
        end

        // table: approach, STOP hysteresis, steady WARN, clamp, WARN entry
        foreach (vt[i]) begin
            distance = vt[i].d;
            sample($sformatf("vec%0d", i), vt[i].avg, vt[i].zone);
        end

        // reset mid-operation from STOP, in the cycle after a tick
        for (int i = 0; i < 4; i++) begin
            distance = 20'd10;
            wait_pulse(cyc);
        end
        @(negedge clk);
        chk("pre_rst_zone", 32'(zone), 32'd2);
        chk("pre_rst_avg", 32'(avg_cm), 32'd10);
        repeat (6) step;
        rst = 1'b1;
        distance = 20'd400;
        @(negedge clk);
        chk("mid_rst_sv", 32'(sample_valid), 32'd0);
        step;
        rst = 1'b0;
        @(negedge clk);
        chk_reset_state("mid_rst");
        cyc = 1;
        while (sample_valid !== 1'b1 && cyc <= 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("post_rst_pulse_cycle", 32'(cyc), 32'd10);
        chk("post_rst_avg", 32'(avg_cm), 32'd400);

        // distance changes in the tick cycle itself: that sample still sees 400
        repeat (6) step;
        distance = 20'd10;
        sample("setup_late", 20'd400, 2'b00);
        sample("setup_next", 20'd302, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
